ysyx_24100005_mem_arbiter: RTL and testbench

Two-requester memory arbiter that shares the single NPC data-memory port between the instruction fetch unit (IFU) and the load/store unit (LSU). It sits between the core front-end/LSU and the DPI-backed memory wrapper (npcmem_read/npcmem_write). It accepts one transaction at a time, grants requesters round-robin, and routes the memory response back to the owner. It replaces the direct combinational memory access in the top level once the core goes multi-cycle.

---
 rtl/ysyx_24100005_bus_pkg.sv | 18 +
 rtl/ysyx_24100005_rr_arb2.sv | 23 ++
 rtl/ysyx_24100005_mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_ysyx_24100005_mem_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24100005_bus_pkg.sv
// Shared types and constants for the NPC memory-port arbiter.
// Requester IDs double as the bit index into the arbiter's valid vector.
package ysyx_24100005_bus_pkg;

    localparam int ADDR_W_DEFAULT = 32;
    localparam int DATA_W_DEFAULT = 32;
    localparam int MASK_W_DEFAULT = 8;

    localparam logic REQ_IFU = 1'b0;
    localparam logic REQ_LSU = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/ysyx_24100005_rr_arb2.sv
// Two-way round-robin picker. Under contention the requester that lost
// last time wins; a lone requester always wins.
module ysyx_24100005_rr_arb2
    import ysyx_24100005_bus_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant,
    output logic       any_valid
);

    always_comb begin
        any_valid = |valid;
        if (&valid) begin
            grant = ~last_grant;
        end else if (valid[0]) begin
            grant = REQ_IFU;
        end else begin
            grant = REQ_LSU;
        end
    end

endmodule

// File: rtl/ysyx_24100005_mem_arbiter.sv
// Shares the single data-memory port between IFU and LSU: one transaction
// in flight, round-robin grant, response routed back to the recorded owner.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no transaction; winner of the picker is accepted this cycle
// ST_ISSUE | latched request presented on mem_req_*, waiting for ready
// ST_WAIT  | request taken by memory, waiting for mem_resp_valid
module ysyx_24100005_mem_arbiter
    import ysyx_24100005_bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int MASK_W = MASK_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    output logic [DATA_W-1:0] ifu_rdata,

    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [MASK_W-1:0] lsu_wmask,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_rdata,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              err
);

    arb_state_e        state;
    arb_state_e        state_nxt;

    logic              grant;
    logic              any_valid;
    logic              accept;
    logic              last_grant;
    logic              owner;

    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;
    logic              err_q;

    ysyx_24100005_rr_arb2 u_rr_arb2 (
        .valid      ({lsu_req_valid, ifu_req_valid}),
        .last_grant (last_grant),
        .grant      (grant),
        .any_valid  (any_valid)
    );

    // Ready is gated by rst so that no requester sees a handshake while the
    // arbiter is held in reset.
    assign accept = (state == ST_IDLE) && any_valid && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (any_valid)      state_nxt = ST_ISSUE;
            ST_ISSUE: if (mem_req_ready)  state_nxt = ST_WAIT;
            ST_WAIT:  if (mem_resp_valid) state_nxt = ST_IDLE;
            default:                      state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= REQ_LSU;
            owner      <= REQ_IFU;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                last_grant <= grant;
                owner      <= grant;
                if (grant == REQ_LSU) begin
                    addr_q  <= lsu_addr;
                    wen_q   <= lsu_wen;
                    wdata_q <= lsu_wdata;
                    wmask_q <= lsu_wmask;
                end else begin
                    addr_q  <= ifu_addr;
                    wen_q   <= 1'b0;
                    wdata_q <= '0;
                    wmask_q <= '0;
                end
            end
            // A response with nothing outstanding is a protocol fault on the
            // memory side; it is dropped and flagged until the next reset.
            if (mem_resp_valid && (state != ST_WAIT)) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        ifu_rdata      = '0;
        lsu_rdata      = '0;
        mem_req_valid  = 1'b0;

        if (accept) begin
            ifu_req_ready = (grant == REQ_IFU);
            lsu_req_ready = (grant == REQ_LSU);
        end

        if (state == ST_ISSUE) begin
            mem_req_valid = 1'b1;
        end

        if ((state == ST_WAIT) && mem_resp_valid) begin
            if (owner == REQ_IFU) begin
                ifu_resp_valid = 1'b1;
                ifu_rdata      = mem_rdata;
            end else begin
                lsu_resp_valid = 1'b1;
                lsu_rdata      = mem_rdata;
            end
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wen   = wen_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ysyx_24100005_mem_arbiter.sv
// Directed and randomized bench for the IFU/LSU memory arbiter, checked
// against a transaction-level reference model.
module tb_ysyx_24100005_mem_arbiter;
    import ysyx_24100005_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ifu_req_valid = 1'b0;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr = '0;
    logic        ifu_resp_valid;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid = 1'b0;
    logic        lsu_req_ready;
    logic [31:0] lsu_addr = '0;
    logic        lsu_wen = 1'b0;
    logic [31:0] lsu_wdata = '0;
    logic [7:0]  lsu_wmask = '0;
    logic        lsu_resp_valid;
    logic [31:0] lsu_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ysyx_24100005_mem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_addr       (ifu_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_rdata      (ifu_rdata),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_addr       (lsu_addr),
        .lsu_wen        (lsu_wen),
        .lsu_wdata      (lsu_wdata),
        .lsu_wmask      (lsu_wmask),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_rdata      (lsu_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata),
        .err            (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs are driven 1 time unit after the rising edge, outputs sampled 1 later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ifu_rdy"},  {31'd0, ifu_req_ready},  32'd0);
        chk({tag, "_lsu_rdy"},  {31'd0, lsu_req_ready},  32'd0);
        chk({tag, "_ifu_resp"}, {31'd0, ifu_resp_valid}, 32'd0);
        chk({tag, "_lsu_resp"}, {31'd0, lsu_resp_valid}, 32'd0);
        chk({tag, "_ifu_rdata"}, ifu_rdata, 32'd0);
        chk({tag, "_lsu_rdata"}, lsu_rdata, 32'd0);
        chk({tag, "_mem_valid"}, {31'd0, mem_req_valid}, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wen"},  {31'd0, mem_wen}, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_mem_wmask"}, {24'd0, mem_wmask}, 32'd0);
        chk({tag, "_err"},      {31'd0, err}, 32'd0);
    endtask

    // One uncontended transaction with memory ready at once and a one-cycle response.
    task automatic run_one(input string tag, input logic who, input logic [31:0] a,
                           input logic w, input logic [31:0] d, input logic [7:0] m,
                           input logic [31:0] rd);
        step();
        if (who == REQ_IFU) begin
            ifu_req_valid = 1'b1;
            ifu_addr      = a;
        end else begin
            lsu_req_valid = 1'b1;
            lsu_addr      = a;
            lsu_wen       = w;
            lsu_wdata     = d;
            lsu_wmask     = m;
        end
        #1;
        chk({tag, "_ifu_rdy"}, {31'd0, ifu_req_ready}, {31'd0, who == REQ_IFU});
        chk({tag, "_lsu_rdy"}, {31'd0, lsu_req_ready}, {31'd0, who == REQ_LSU});
        step();
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        chk({tag, "_mem_valid"}, {31'd0, mem_req_valid}, 32'd1);
        chk({tag, "_mem_addr"}, mem_addr, a);
        chk({tag, "_mem_wen"}, {31'd0, mem_wen}, (who == REQ_LSU) ? {31'd0, w} : 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, (who == REQ_LSU) ? d : 32'd0);
        chk({tag, "_mem_wmask"}, {24'd0, mem_wmask}, (who == REQ_LSU) ? {24'd0, m} : 32'd0);
        step();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = rd;
        #1;
        chk({tag, "_ifu_resp"}, {31'd0, ifu_resp_valid}, {31'd0, who == REQ_IFU});
        chk({tag, "_lsu_resp"}, {31'd0, lsu_resp_valid}, {31'd0, who == REQ_LSU});
        chk({tag, "_ifu_rdata"}, ifu_rdata, (who == REQ_IFU) ? rd : 32'd0);
        chk({tag, "_lsu_rdata"}, lsu_rdata, (who == REQ_LSU) ? rd : 32'd0);
        step();
        mem_resp_valid = 1'b0;
        #1;
        chk({tag, "_ifu_resp_end"}, {31'd0, ifu_resp_valid}, 32'd0);
        chk({tag, "_lsu_resp_end"}, {31'd0, lsu_resp_valid}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        exp_owner;
        logic [31:0] exp_addr;
        // reference-model state
        bit          ifu_pend, lsu_pend, busy, issued, own, last;
        bit          exp_i, exp_l, resp;
        logic [31:0] ifu_a, lsu_a, lsu_d, t_addr, t_wd;
        logic [7:0]  lsu_m, t_wm;
        bit          lsu_w, t_wen;

        // Reset asserted mid-cycle with a request pending: everything reads 0.
        #3;
        lsu_req_valid = 1'b1;
        rst = 1'b1;
        #1;
        chk_all_zero("reset");
        step();
        step();
        rst = 1'b0;
        lsu_req_valid = 1'b0;

        // Contention: both requesters held valid for four transactions.
        step();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0010;
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_0200;
        lsu_wen       = 1'b0;
        lsu_wdata     = 32'h0;
        lsu_wmask     = 8'h0;
        for (int k = 0; k < 4; k++) begin
            exp_owner = (k % 2 == 0) ? REQ_IFU : REQ_LSU;
            exp_addr  = (exp_owner == REQ_IFU) ? 32'h8000_0010 : 32'h8000_0200;
            #1;
            chk("cont_ifu_rdy", {31'd0, ifu_req_ready}, {31'd0, exp_owner == REQ_IFU});
            chk("cont_lsu_rdy", {31'd0, lsu_req_ready}, {31'd0, exp_owner == REQ_LSU});
            step();
            mem_req_ready = 1'b1;
            #1;
            chk("cont_mem_valid", {31'd0, mem_req_valid}, 32'd1);
            chk("cont_mem_addr", mem_addr, exp_addr);
            chk("cont_busy_ifu_rdy", {31'd0, ifu_req_ready}, 32'd0);
            chk("cont_busy_lsu_rdy", {31'd0, lsu_req_ready}, 32'd0);
            step();
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b1;
            mem_rdata      = 32'h1111_0000 + 32'(k);
            #1;
            chk("cont_ifu_resp", {31'd0, ifu_resp_valid}, {31'd0, exp_owner == REQ_IFU});
            chk("cont_lsu_resp", {31'd0, lsu_resp_valid}, {31'd0, exp_owner == REQ_LSU});
            chk("cont_ifu_rdata", ifu_rdata, (exp_owner == REQ_IFU) ? 32'h1111_0000 + 32'(k) : 32'd0);
            chk("cont_lsu_rdata", lsu_rdata, (exp_owner == REQ_LSU) ? 32'h1111_0000 + 32'(k) : 32'd0);
            step();
            mem_resp_valid = 1'b0;
        end
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;

        // Single IFU fetch.
        run_one("fetch", REQ_IFU, 32'h8000_0000, 1'b0, 32'h0, 8'h0, 32'h0010_0073);

        // LSU store with memory stalling three cycles.
        step();
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_0100;
        lsu_wen       = 1'b1;
        lsu_wdata     = 32'hDEAD_BEEF;
        lsu_wmask     = 8'h0F;
        #1;
        chk("st_lsu_rdy", {31'd0, lsu_req_ready}, 32'd1);
        chk("st_ifu_rdy", {31'd0, ifu_req_ready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            mem_req_ready = (i == 3);
            #1;
            chk("st_mem_valid", {31'd0, mem_req_valid}, 32'd1);
            chk("st_mem_addr", mem_addr, 32'h8000_0100);
            chk("st_mem_wen", {31'd0, mem_wen}, 32'd1);
            chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
            chk("st_mem_wmask", {24'd0, mem_wmask}, 32'h0F);
            chk("st_lsu_rdy_busy", {31'd0, lsu_req_ready}, 32'd0);
        end
        step();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h1234_5678;
        #1;
        chk("st_lsu_resp", {31'd0, lsu_resp_valid}, 32'd1);
        chk("st_lsu_rdata", lsu_rdata, 32'h1234_5678);
        chk("st_ifu_resp", {31'd0, ifu_resp_valid}, 32'd0);
        chk("st_lsu_rdy_wait", {31'd0, lsu_req_ready}, 32'd0);
        chk("st_mem_valid_wait", {31'd0, mem_req_valid}, 32'd0);
        lsu_req_valid = 1'b0;
        step();
        mem_resp_valid = 1'b0;
        #1;
        chk("st_lsu_resp_end", {31'd0, lsu_resp_valid}, 32'd0);

        // Spurious response while idle.
        step();
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'hA5A5_A5A5;
        #1;
        chk("spur_ifu_resp", {31'd0, ifu_resp_valid}, 32'd0);
        chk("spur_lsu_resp", {31'd0, lsu_resp_valid}, 32'd0);
        chk("spur_ifu_rdata", ifu_rdata, 32'd0);
        chk("spur_lsu_rdata", lsu_rdata, 32'd0);
        step();
        mem_resp_valid = 1'b0;
        #1;
        chk("spur_err_set", {31'd0, err}, 32'd1);
        step();
        chk("spur_err_sticky", {31'd0, err}, 32'd1);
        run_one("post_spur", REQ_LSU, 32'h8000_0300, 1'b0, 32'h0, 8'h0, 32'hCAFE_F00D);
        chk("post_spur_err", {31'd0, err}, 32'd1);

        // Reset while waiting for a response.
        step();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0400;
        #1;
        chk("rstw_ifu_rdy", {31'd0, ifu_req_ready}, 32'd1);
        step();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready  = 1'b0;
        rst            = 1'b1;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h7777_7777;
        #1;
        chk_all_zero("rst_wait");
        step();
        chk("rstw_err_in_rst", {31'd0, err}, 32'd0);
        mem_resp_valid = 1'b0;
        rst = 1'b0;
        step();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0500;
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_0600;
        lsu_wen       = 1'b0;
        #1;
        chk("rstw_first_ifu", {31'd0, ifu_req_ready}, 32'd1);
        chk("rstw_first_lsu", {31'd0, lsu_req_ready}, 32'd0);
        step();
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        chk("rstw_mem_addr", mem_addr, 32'h8000_0500);
        step();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h0BAD_C0DE;
        #1;
        chk("rstw_ifu_resp", {31'd0, ifu_resp_valid}, 32'd1);
        chk("rstw_ifu_rdata", ifu_rdata, 32'h0BAD_C0DE);
        chk("rstw_err", {31'd0, err}, 32'd0);
        step();
        mem_resp_valid = 1'b0;

        // Randomized traffic against a transaction-level model.
        rst = 1'b1;
        step();
        rst = 1'b0;
        ifu_pend = 0; lsu_pend = 0; busy = 0; issued = 0; own = REQ_IFU; last = REQ_LSU;
        ifu_a = 0; lsu_a = 0; lsu_d = 0; lsu_m = 0; lsu_w = 0;
        t_addr = 0; t_wd = 0; t_wm = 0; t_wen = 0;
        for (int c = 0; c < 3000; c++) begin
            step();
            if (!ifu_pend && $urandom_range(0, 2) == 0) begin
                ifu_pend = 1;
                ifu_a    = $urandom;
            end
            if (!lsu_pend && $urandom_range(0, 2) == 0) begin
                lsu_pend = 1;
                lsu_a    = $urandom;
                lsu_w    = 1'($urandom_range(0, 1));
                lsu_d    = $urandom;
                lsu_m    = 8'($urandom);
            end
            ifu_req_valid  = ifu_pend;
            ifu_addr       = ifu_a;
            lsu_req_valid  = lsu_pend;
            lsu_addr       = lsu_a;
            lsu_wen        = lsu_w;
            lsu_wdata      = lsu_d;
            lsu_wmask      = lsu_m;
            mem_req_ready  = ($urandom_range(0, 2) != 0);
            mem_resp_valid = busy && issued && ($urandom_range(0, 2) == 0);
            mem_rdata      = $urandom;
            #1;
            exp_i = !busy && ifu_pend && (!lsu_pend || last == REQ_LSU);
            exp_l = !busy && lsu_pend && (!ifu_pend || last == REQ_IFU);
            resp  = busy && issued && mem_resp_valid;
            chk("rnd_ifu_rdy", {31'd0, ifu_req_ready}, {31'd0, exp_i});
            chk("rnd_lsu_rdy", {31'd0, lsu_req_ready}, {31'd0, exp_l});
            chk("rnd_mem_valid", {31'd0, mem_req_valid}, {31'd0, busy && !issued});
            if (busy && !issued) begin
                chk("rnd_mem_addr", mem_addr, t_addr);
                chk("rnd_mem_wen", {31'd0, mem_wen}, {31'd0, t_wen});
                chk("rnd_mem_wdata", mem_wdata, t_wd);
                chk("rnd_mem_wmask", {24'd0, mem_wmask}, {24'd0, t_wm});
            end
            chk("rnd_ifu_resp", {31'd0, ifu_resp_valid}, {31'd0, resp && own == REQ_IFU});
            chk("rnd_lsu_resp", {31'd0, lsu_resp_valid}, {31'd0, resp && own == REQ_LSU});
            chk("rnd_ifu_rdata", ifu_rdata, (resp && own == REQ_IFU) ? mem_rdata : 32'd0);
            chk("rnd_lsu_rdata", lsu_rdata, (resp && own == REQ_LSU) ? mem_rdata : 32'd0);
            chk("rnd_err", {31'd0, err}, 32'd0);
            if (!busy) begin
                if (exp_i) begin
                    busy = 1; issued = 0; own = REQ_IFU; last = REQ_IFU; ifu_pend = 0;
                    t_addr = ifu_a; t_wen = 0; t_wd = 0; t_wm = 0;
                end else if (exp_l) begin
                    busy = 1; issued = 0; own = REQ_LSU; last = REQ_LSU; lsu_pend = 0;
                    t_addr = lsu_a; t_wen = lsu_w; t_wd = lsu_d; t_wm = lsu_m;
                end
            end else if (!issued) begin
                if (mem_req_ready) issued = 1;
            end else if (mem_resp_valid) begin
                busy = 0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
